// File: rtl/rv32_irj_core.sv
// Five-stage RV32 integer pipeline (R-type ALU ops, I-type ALU ops, JAL) with EX forwarding.
// Includes the instruction ROM and register file submodules; pipeline registers are exposed as debug outputs.

module InstrRom (
  input  logic [7:0]  i_addr,
  output logic [31:0] o_data
);
  logic [31:0] rom [0:255];

  assign o_data = rom[i_addr];
endmodule

module RegFile (
  input  logic        i_clk,
  input  logic        i_wrEn,
  input  logic [4:0]  i_wrAddr,
  input  logic [31:0] i_wrData,
  input  logic [4:0]  i_rdAddr1,
  input  logic [4:0]  i_rdAddr2,
  output logic [31:0] o_rdData1,
  output logic [31:0] o_rdData2
);
  logic [31:0] regsfile_ [0:31];

  always_ff @(posedge i_clk) begin
    if (i_wrEn && i_wrAddr != 5'd0)
      regsfile_[i_wrAddr] <= i_wrData;
  end

  // A write landing this cycle is bypassed so ID never sees a stale value.
  always_comb begin
    o_rdData1 = regsfile_[i_rdAddr1];
    o_rdData2 = regsfile_[i_rdAddr2];
    if (i_wrEn && i_wrAddr == i_rdAddr1) o_rdData1 = i_wrData;
    if (i_wrEn && i_wrAddr == i_rdAddr2) o_rdData2 = i_wrData;
    if (i_rdAddr1 == 5'd0) o_rdData1 = 32'd0;
    if (i_rdAddr2 == 5'd0) o_rdData2 = 32'd0;
  end
endmodule

module rv32_irj_core (
  input  logic        clk_i_core,
  input  logic        reset_i_core,
  output logic [31:0] debug_IFID_pcAddr,
  output logic [31:0] debug_IFID_instr,
  output logic        debug_IDEXE_regWrite,
  output logic [3:0]  debug_IDEXE_ALUOp,
  output logic [31:0] debug_IDEXE_imm32,
  output logic [4:0]  debug_IDEXE_Addr1,
  output logic [4:0]  debug_IDEXE_Addr2,
  output logic [31:0] debug_IDEXE_Data1,
  output logic [31:0] debug_IDEXE_Data2,
  output logic [31:0] debug_EXEMEM_WrtData,
  output logic [4:0]  debug_EXEMEM_WrtAddr,
  output logic        debug_EXEMEM_WrtEn,
  output logic [4:0]  debug_EXEMEM_Addr1,
  output logic [4:0]  debug_EXEMEM_Addr2,
  output logic [31:0] debug_EXEMEM_Data1,
  output logic [31:0] debug_EXEMEM_Data2,
  output logic [31:0] debug_MEMWB_WrtData,
  output logic [4:0]  debug_MEMWB_WrtAddr,
  output logic        debug_MEMWB_WrtEn,
  output logic [4:0]  debug_MEMWB_Addr1,
  output logic [4:0]  debug_MEMWB_Addr2,
  output logic [31:0] debug_MEMWB_Data1,
  output logic [31:0] debug_MEMWB_Data2,
  output logic [31:0] debug_WB_WrtData,
  output logic [4:0]  debug_WB_WrtAddr,
  output logic        debug_WB_WrtEn
);
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR  = 4'd8, ALU_AND  = 4'd9
  } aluOp_t;

  logic [31:0] r_pc, r_ifidPc, r_ifidInstr;
  logic        r_idexRegWrite, r_idexUseRs1, r_idexUseRs2, r_idexOp2Imm;
  aluOp_t      r_idexAluOp;
  logic [31:0] r_idexImm, r_idexData1, r_idexData2;
  logic [4:0]  r_idexAddr1, r_idexAddr2, r_idexRd;
  logic [31:0] r_exmemWrtData, r_exmemData1, r_exmemData2;
  logic [4:0]  r_exmemWrtAddr, r_exmemAddr1, r_exmemAddr2;
  logic        r_exmemWrtEn;
  logic [31:0] r_memwbWrtData, r_memwbData1, r_memwbData2;
  logic [4:0]  r_memwbWrtAddr, r_memwbAddr1, r_memwbAddr2;
  logic        r_memwbWrtEn;

  logic [31:0] w_romData, w_rdData1, w_rdData2, w_jImm;
  logic [6:0]  w_opcode, w_funct7;
  logic [2:0]  w_funct3;
  logic        w_decRegWrite, w_decUseRs1, w_decUseRs2, w_decOp2Imm, w_decIsJal;
  aluOp_t      w_decAluOp;
  logic [31:0] w_decImm;
  logic [4:0]  w_decAddr1, w_decAddr2;
  logic [31:0] w_exOp1, w_exOp2, w_exB, w_aluRes;
  logic        w_rfWrEn;

  InstrRom ROM_InstrMem0 (
    .i_addr (r_pc[9:2]),
    .o_data (w_romData)
  );

  // In-flight writebacks are dropped while reset is asserted.
  assign w_rfWrEn = r_memwbWrtEn & ~reset_i_core;

  RegFile RegFile0 (
    .i_clk     (clk_i_core),
    .i_wrEn    (w_rfWrEn),
    .i_wrAddr  (r_memwbWrtAddr),
    .i_wrData  (r_memwbWrtData),
    .i_rdAddr1 (w_decAddr1),
    .i_rdAddr2 (w_decAddr2),
    .o_rdData1 (w_rdData1),
    .o_rdData2 (w_rdData2)
  );

  assign w_opcode = r_ifidInstr[6:0];
  assign w_funct3 = r_ifidInstr[14:12];
  assign w_funct7 = r_ifidInstr[31:25];
  assign w_jImm   = {{11{r_ifidInstr[31]}}, r_ifidInstr[31], r_ifidInstr[19:12],
                     r_ifidInstr[20], r_ifidInstr[30:21], 1'b0};

  always_comb begin
    w_decRegWrite = 1'b0;
    w_decUseRs1   = 1'b0;
    w_decUseRs2   = 1'b0;
    w_decOp2Imm   = 1'b0;
    w_decIsJal    = 1'b0;
    w_decAluOp    = ALU_ADD;
    w_decImm      = 32'd0;
    w_decAddr1    = r_ifidInstr[19:15];
    w_decAddr2    = r_ifidInstr[24:20];
    case (w_opcode)
      7'b0110011: begin
        if (w_funct7 == 7'h00 ||
            (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))) begin
          w_decRegWrite = 1'b1;
          w_decUseRs1   = 1'b1;
          w_decUseRs2   = 1'b1;
          case (w_funct3)
            3'b000: w_decAluOp = w_funct7[5] ? ALU_SUB : ALU_ADD;
            3'b001: w_decAluOp = ALU_SLL;
            3'b010: w_decAluOp = ALU_SLT;
            3'b011: w_decAluOp = ALU_SLTU;
            3'b100: w_decAluOp = ALU_XOR;
            3'b101: w_decAluOp = w_funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110: w_decAluOp = ALU_OR;
            default: w_decAluOp = ALU_AND;
          endcase
        end
      end
      7'b0010011: begin
        // Shift-immediates carry a funct7 that must be a legal encoding.
        if ((w_funct3 != 3'b001 && w_funct3 != 3'b101) ||
            (w_funct3 == 3'b001 && w_funct7 == 7'h00) ||
            (w_funct3 == 3'b101 && (w_funct7 == 7'h00 || w_funct7 == 7'h20))) begin
          w_decRegWrite = 1'b1;
          w_decUseRs1   = 1'b1;
          w_decOp2Imm   = 1'b1;
          w_decImm      = {{20{r_ifidInstr[31]}}, r_ifidInstr[31:20]};
          case (w_funct3)
            3'b000: w_decAluOp = ALU_ADD;
            3'b001: w_decAluOp = ALU_SLL;
            3'b010: w_decAluOp = ALU_SLT;
            3'b011: w_decAluOp = ALU_SLTU;
            3'b100: w_decAluOp = ALU_XOR;
            3'b101: w_decAluOp = w_funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110: w_decAluOp = ALU_OR;
            default: w_decAluOp = ALU_AND;
          endcase
        end
      end
      7'b1101111: begin
        w_decIsJal    = 1'b1;
        w_decRegWrite = 1'b1;
        w_decOp2Imm   = 1'b1;
        w_decImm      = 32'd4;
        w_decAddr1    = 5'd0;
        w_decAddr2    = 5'd0;
      end
      default: ;
    endcase
  end

  // JAL redirects from ID, so the word fetched alongside it is replaced by a NOP.
  always_ff @(posedge clk_i_core) begin
    if (reset_i_core) begin
      r_pc        <= 32'd0;
      r_ifidPc    <= 32'd0;
      r_ifidInstr <= 32'd0;
    end else if (w_decIsJal) begin
      r_pc        <= r_ifidPc + w_jImm;
      r_ifidPc    <= 32'd0;
      r_ifidInstr <= 32'h0000_0013;
    end else begin
      r_pc        <= r_pc + 32'd4;
      r_ifidPc    <= r_pc;
      r_ifidInstr <= w_romData;
    end
  end

  always_ff @(posedge clk_i_core) begin
    if (reset_i_core) begin
      r_idexRegWrite <= 1'b0;
      r_idexUseRs1   <= 1'b0;
      r_idexUseRs2   <= 1'b0;
      r_idexOp2Imm   <= 1'b0;
      r_idexAluOp    <= ALU_ADD;
      r_idexImm      <= 32'd0;
      r_idexAddr1    <= 5'd0;
      r_idexAddr2    <= 5'd0;
      r_idexRd       <= 5'd0;
      r_idexData1    <= 32'd0;
      r_idexData2    <= 32'd0;
    end else begin
      r_idexRegWrite <= w_decRegWrite;
      r_idexUseRs1   <= w_decUseRs1;
      r_idexUseRs2   <= w_decUseRs2;
      r_idexOp2Imm   <= w_decOp2Imm;
      r_idexAluOp    <= w_decAluOp;
      r_idexImm      <= w_decImm;
      r_idexAddr1    <= w_decAddr1;
      r_idexAddr2    <= w_decAddr2;
      r_idexRd       <= r_ifidInstr[11:7];
      r_idexData1    <= w_decIsJal ? r_ifidPc : w_rdData1;
      r_idexData2    <= w_decIsJal ? 32'd0 : w_rdData2;
    end
  end

  // The youngest producer (EX/MEM) wins over the older one (MEM/WB).
  always_comb begin
    w_exOp1 = r_idexData1;
    w_exOp2 = r_idexData2;
    if (r_idexUseRs1) begin
      if (r_exmemWrtEn && r_exmemWrtAddr != 5'd0 && r_exmemWrtAddr == r_idexAddr1)
        w_exOp1 = r_exmemWrtData;
      else if (r_memwbWrtEn && r_memwbWrtAddr != 5'd0 && r_memwbWrtAddr == r_idexAddr1)
        w_exOp1 = r_memwbWrtData;
    end
    if (r_idexUseRs2) begin
      if (r_exmemWrtEn && r_exmemWrtAddr != 5'd0 && r_exmemWrtAddr == r_idexAddr2)
        w_exOp2 = r_exmemWrtData;
      else if (r_memwbWrtEn && r_memwbWrtAddr != 5'd0 && r_memwbWrtAddr == r_idexAddr2)
        w_exOp2 = r_memwbWrtData;
    end
  end

  assign w_exB = r_idexOp2Imm ? r_idexImm : w_exOp2;

  always_comb begin
    w_aluRes = 32'd0;
    case (r_idexAluOp)
      ALU_ADD:  w_aluRes = w_exOp1 + w_exB;
      ALU_SUB:  w_aluRes = w_exOp1 - w_exB;
      ALU_SLL:  w_aluRes = w_exOp1 << w_exB[4:0];
      ALU_SLT:  w_aluRes = {31'd0, $signed(w_exOp1) < $signed(w_exB)};
      ALU_SLTU: w_aluRes = {31'd0, w_exOp1 < w_exB};
      ALU_XOR:  w_aluRes = w_exOp1 ^ w_exB;
      ALU_SRL:  w_aluRes = w_exOp1 >> w_exB[4:0];
      ALU_SRA:  w_aluRes = $unsigned($signed(w_exOp1) >>> w_exB[4:0]);
      ALU_OR:   w_aluRes = w_exOp1 | w_exB;
      ALU_AND:  w_aluRes = w_exOp1 & w_exB;
      default:  w_aluRes = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i_core) begin
    if (reset_i_core) begin
      r_exmemWrtData <= 32'd0;
      r_exmemWrtAddr <= 5'd0;
      r_exmemWrtEn   <= 1'b0;
      r_exmemAddr1   <= 5'd0;
      r_exmemAddr2   <= 5'd0;
      r_exmemData1   <= 32'd0;
      r_exmemData2   <= 32'd0;
      r_memwbWrtData <= 32'd0;
      r_memwbWrtAddr <= 5'd0;
      r_memwbWrtEn   <= 1'b0;
      r_memwbAddr1   <= 5'd0;
      r_memwbAddr2   <= 5'd0;
      r_memwbData1   <= 32'd0;
      r_memwbData2   <= 32'd0;
    end else begin
      r_exmemWrtData <= w_aluRes;
      r_exmemWrtAddr <= r_idexRd;
      r_exmemWrtEn   <= r_idexRegWrite;
      r_exmemAddr1   <= r_idexAddr1;
      r_exmemAddr2   <= r_idexAddr2;
      r_exmemData1   <= w_exOp1;
      r_exmemData2   <= w_exOp2;
      r_memwbWrtData <= r_exmemWrtData;
      r_memwbWrtAddr <= r_exmemWrtAddr;
      r_memwbWrtEn   <= r_exmemWrtEn;
      r_memwbAddr1   <= r_exmemAddr1;
      r_memwbAddr2   <= r_exmemAddr2;
      r_memwbData1   <= r_exmemData1;
      r_memwbData2   <= r_exmemData2;
    end
  end

  assign debug_IFID_pcAddr    = r_ifidPc;
  assign debug_IFID_instr     = r_ifidInstr;
  assign debug_IDEXE_regWrite = r_idexRegWrite;
  assign debug_IDEXE_ALUOp    = r_idexAluOp;
  assign debug_IDEXE_imm32    = r_idexImm;
  assign debug_IDEXE_Addr1    = r_idexAddr1;
  assign debug_IDEXE_Addr2    = r_idexAddr2;
  assign debug_IDEXE_Data1    = r_idexData1;
  assign debug_IDEXE_Data2    = r_idexData2;
  assign debug_EXEMEM_WrtData = r_exmemWrtData;
  assign debug_EXEMEM_WrtAddr = r_exmemWrtAddr;
  assign debug_EXEMEM_WrtEn   = r_exmemWrtEn;
  assign debug_EXEMEM_Addr1   = r_exmemAddr1;
  assign debug_EXEMEM_Addr2   = r_exmemAddr2;
  assign debug_EXEMEM_Data1   = r_exmemData1;
  assign debug_EXEMEM_Data2   = r_exmemData2;
  assign debug_MEMWB_WrtData  = r_memwbWrtData;
  assign debug_MEMWB_WrtAddr  = r_memwbWrtAddr;
  assign debug_MEMWB_WrtEn    = r_memwbWrtEn;
  assign debug_MEMWB_Addr1    = r_memwbAddr1;
  assign debug_MEMWB_Addr2    = r_memwbAddr2;
  assign debug_MEMWB_Data1    = r_memwbData1;
  assign debug_MEMWB_Data2    = r_memwbData2;
  assign debug_WB_WrtData     = r_memwbWrtData;
  assign debug_WB_WrtAddr     = r_memwbWrtAddr;
  assign debug_WB_WrtEn       = r_memwbWrtEn;
endmodule

// File: tb/tb_rv32_irj_core.sv
// Directed testbench for rv32_irj_core: small preloaded programs with hand-computed results.
`timescale 1ns/1ps

module tb_rv32_irj_core;
  logic        clk, reset;
  logic [31:0] ifidPc, ifidInstr;
  logic        idexRegWrite;
  logic [3:0]  idexAluOp;
  logic [31:0] idexImm, idexData1, idexData2;
  logic [4:0]  idexAddr1, idexAddr2;
  logic [31:0] exmemWrtData, exmemData1, exmemData2;
  logic [4:0]  exmemWrtAddr, exmemAddr1, exmemAddr2;
  logic        exmemWrtEn;
  logic [31:0] memwbWrtData, memwbData1, memwbData2;
  logic [4:0]  memwbWrtAddr, memwbAddr1, memwbAddr2;
  logic        memwbWrtEn;
  logic [31:0] wbWrtData;
  logic [4:0]  wbWrtAddr;
  logic        wbWrtEn;
  logic        anyDebugSet;

  int compareCount = 0;
  int failCount    = 0;

  logic [31:0] tblInstr [19];
  logic [3:0]  tblOp    [19];
  logic [31:0] tblImm   [19];
  logic [31:0] tblRes   [19];
  logic [31:0] pcSeq    [5];

  rv32_irj_core dut (
    .clk_i_core           (clk),
    .reset_i_core         (reset),
    .debug_IFID_pcAddr    (ifidPc),
    .debug_IFID_instr     (ifidInstr),
    .debug_IDEXE_regWrite (idexRegWrite),
    .debug_IDEXE_ALUOp    (idexAluOp),
    .debug_IDEXE_imm32    (idexImm),
    .debug_IDEXE_Addr1    (idexAddr1),
    .debug_IDEXE_Addr2    (idexAddr2),
    .debug_IDEXE_Data1    (idexData1),
    .debug_IDEXE_Data2    (idexData2),
    .debug_EXEMEM_WrtData (exmemWrtData),
    .debug_EXEMEM_WrtAddr (exmemWrtAddr),
    .debug_EXEMEM_WrtEn   (exmemWrtEn),
    .debug_EXEMEM_Addr1   (exmemAddr1),
    .debug_EXEMEM_Addr2   (exmemAddr2),
    .debug_EXEMEM_Data1   (exmemData1),
    .debug_EXEMEM_Data2   (exmemData2),
    .debug_MEMWB_WrtData  (memwbWrtData),
    .debug_MEMWB_WrtAddr  (memwbWrtAddr),
    .debug_MEMWB_WrtEn    (memwbWrtEn),
    .debug_MEMWB_Addr1    (memwbAddr1),
    .debug_MEMWB_Addr2    (memwbAddr2),
    .debug_MEMWB_Data1    (memwbData1),
    .debug_MEMWB_Data2    (memwbData2),
    .debug_WB_WrtData     (wbWrtData),
    .debug_WB_WrtAddr     (wbWrtAddr),
    .debug_WB_WrtEn       (wbWrtEn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign anyDebugSet = |{ifidPc, ifidInstr, idexRegWrite, idexAluOp, idexImm, idexAddr1,
                         idexAddr2, idexData1, idexData2, exmemWrtData, exmemWrtAddr,
                         exmemWrtEn, exmemAddr1, exmemAddr2, exmemData1, exmemData2,
                         memwbWrtData, memwbWrtAddr, memwbWrtEn, memwbAddr1, memwbAddr2,
                         memwbData1, memwbData2, wbWrtData, wbWrtAddr, wbWrtEn};

  function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] encJ(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and leave the bench 1ns past the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges and refills the ROM with NOPs ready for the next program.
  task automatic resetCore();
    reset = 1'b1;
    applyStimulus(2);
    for (int i = 0; i < 256; i++) dut.ROM_InstrMem0.rom[i] = 32'h0000_0013;
  endtask

  task automatic setVec(input int k, input logic [31:0] instr, input logic [3:0] op,
                        input logic [31:0] imm, input logic [31:0] res);
    tblInstr[k] = instr;
    tblOp[k]    = op;
    tblImm[k]   = imm;
    tblRes[k]   = res;
  endtask

  initial begin
    reset = 1'b1;
    $display("[TB] starting rv32_irj_core bench");

    // Reset state
    resetCore();
    checkOutput("rst_anyDebug", 32'(anyDebugSet), 32'd0);
    checkOutput("rst_wbEn", 32'(wbWrtEn), 32'd0);

    // add x3,x1,x2 latency through every stage
    dut.RegFile0.regsfile_[1] = 32'd5;
    dut.RegFile0.regsfile_[2] = 32'd7;
    dut.RegFile0.regsfile_[3] = 32'd0;
    dut.ROM_InstrMem0.rom[0]  = encR(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("add_ifidInstr", ifidInstr, 32'h0020_81B3);
    checkOutput("add_ifidPc", ifidPc, 32'd0);
    applyStimulus(1);
    checkOutput("add_idexData1", idexData1, 32'd5);
    checkOutput("add_idexData2", idexData2, 32'd7);
    checkOutput("add_idexAddr2", 32'(idexAddr2), 32'd2);
    checkOutput("add_idexRegWrite", 32'(idexRegWrite), 32'd1);
    applyStimulus(1);
    checkOutput("add_exmemData", exmemWrtData, 32'd12);
    applyStimulus(1);
    checkOutput("add_wbData", wbWrtData, 32'd12);
    checkOutput("add_wbAddr", 32'(wbWrtAddr), 32'd3);
    checkOutput("add_wbEn", 32'(wbWrtEn), 32'd1);
    checkOutput("add_x3_before", dut.RegFile0.regsfile_[3], 32'd0);
    applyStimulus(1);
    checkOutput("add_x3", dut.RegFile0.regsfile_[3], 32'd12);

    // Every ALU op on x1=0x80000005, x2=3, results in x10..x28
    setVec(0,  encR(7'h00, 5'd2, 5'd1, 3'd0, 5'd10), 4'd0, 32'd0, 32'h8000_0008);
    setVec(1,  encR(7'h20, 5'd2, 5'd1, 3'd0, 5'd11), 4'd1, 32'd0, 32'h8000_0002);
    setVec(2,  encR(7'h00, 5'd2, 5'd1, 3'd1, 5'd12), 4'd2, 32'd0, 32'h0000_0028);
    setVec(3,  encR(7'h00, 5'd2, 5'd1, 3'd2, 5'd13), 4'd3, 32'd0, 32'd1);
    setVec(4,  encR(7'h00, 5'd2, 5'd1, 3'd3, 5'd14), 4'd4, 32'd0, 32'd0);
    setVec(5,  encR(7'h00, 5'd2, 5'd1, 3'd4, 5'd15), 4'd5, 32'd0, 32'h8000_0006);
    setVec(6,  encR(7'h00, 5'd2, 5'd1, 3'd5, 5'd16), 4'd6, 32'd0, 32'h1000_0000);
    setVec(7,  encR(7'h20, 5'd2, 5'd1, 3'd5, 5'd17), 4'd7, 32'd0, 32'hF000_0000);
    setVec(8,  encR(7'h00, 5'd2, 5'd1, 3'd6, 5'd18), 4'd8, 32'd0, 32'h8000_0007);
    setVec(9,  encR(7'h00, 5'd2, 5'd1, 3'd7, 5'd19), 4'd9, 32'd0, 32'h0000_0001);
    setVec(10, encI(12'hFFA, 5'd1, 3'd0, 5'd20), 4'd0, 32'hFFFF_FFFA, 32'h7FFF_FFFF);
    setVec(11, encI(12'h001, 5'd1, 3'd2, 5'd21), 4'd3, 32'h0000_0001, 32'd1);
    setVec(12, encI(12'hFFF, 5'd1, 3'd3, 5'd22), 4'd4, 32'hFFFF_FFFF, 32'd1);
    setVec(13, encI(12'hFFF, 5'd1, 3'd4, 5'd23), 4'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFA);
    setVec(14, encI(12'h0F0, 5'd1, 3'd6, 5'd24), 4'd8, 32'h0000_00F0, 32'h8000_00F5);
    setVec(15, encI(12'h7FF, 5'd1, 3'd7, 5'd25), 4'd9, 32'h0000_07FF, 32'h0000_0005);
    setVec(16, encI(12'h004, 5'd1, 3'd1, 5'd26), 4'd2, 32'h0000_0004, 32'h0000_0050);
    setVec(17, encI(12'h01F, 5'd1, 3'd5, 5'd27), 4'd6, 32'h0000_001F, 32'h0000_0001);
    setVec(18, encI(12'h401, 5'd1, 3'd5, 5'd28), 4'd7, 32'h0000_0401, 32'hC000_0002);
    resetCore();
    dut.RegFile0.regsfile_[1] = 32'h8000_0005;
    dut.RegFile0.regsfile_[2] = 32'd3;
    for (int k = 0; k < 19; k++) begin
      dut.ROM_InstrMem0.rom[k]       = tblInstr[k];
      dut.RegFile0.regsfile_[10 + k] = 32'hDEAD_BEEF;
    end
    reset = 1'b0;
    applyStimulus(1);
    for (int k = 0; k < 19; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("alu%0d_op", k), 32'(idexAluOp), 32'(tblOp[k]));
      checkOutput($sformatf("alu%0d_imm", k), idexImm, tblImm[k]);
    end
    applyStimulus(4);
    for (int k = 0; k < 19; k++)
      checkOutput($sformatf("alu%0d_res", k), dut.RegFile0.regsfile_[10 + k], tblRes[k]);

    // Back-to-back forwarding, ID write-through and forwarding priority
    resetCore();
    dut.ROM_InstrMem0.rom[0] = encI(12'hFFF, 5'd0, 3'd0, 5'd4);
    dut.ROM_InstrMem0.rom[1] = encI(12'h404, 5'd4, 3'd5, 5'd5);
    dut.ROM_InstrMem0.rom[2] = encR(7'h00, 5'd4, 5'd0, 3'd3, 5'd6);
    dut.ROM_InstrMem0.rom[3] = encR(7'h00, 5'd0, 5'd4, 3'd6, 5'd13);
    dut.ROM_InstrMem0.rom[4] = encI(12'h001, 5'd0, 3'd0, 5'd14);
    dut.ROM_InstrMem0.rom[5] = encI(12'h002, 5'd0, 3'd0, 5'd14);
    dut.ROM_InstrMem0.rom[6] = encR(7'h00, 5'd14, 5'd14, 3'd0, 5'd15);
    dut.RegFile0.regsfile_[4]  = 32'd0;
    dut.RegFile0.regsfile_[5]  = 32'd0;
    dut.RegFile0.regsfile_[6]  = 32'd0;
    dut.RegFile0.regsfile_[13] = 32'd0;
    dut.RegFile0.regsfile_[14] = 32'd0;
    dut.RegFile0.regsfile_[15] = 32'd0;
    reset = 1'b0;
    applyStimulus(3);
    checkOutput("fwd_srai_idexStale", idexData1, 32'd0);
    applyStimulus(1);
    checkOutput("fwd_srai_exmemOp1", exmemData1, 32'hFFFF_FFFF);
    checkOutput("fwd_srai_result", exmemWrtData, 32'hFFFF_FFFF);
    applyStimulus(1);
    checkOutput("fwd_or_idBypass", idexData1, 32'hFFFF_FFFF);
    applyStimulus(7);
    checkOutput("fwd_x4", dut.RegFile0.regsfile_[4], 32'hFFFF_FFFF);
    checkOutput("fwd_x5", dut.RegFile0.regsfile_[5], 32'hFFFF_FFFF);
    checkOutput("fwd_x6", dut.RegFile0.regsfile_[6], 32'd1);
    checkOutput("fwd_x13", dut.RegFile0.regsfile_[13], 32'hFFFF_FFFF);
    checkOutput("fwd_x15_priority", dut.RegFile0.regsfile_[15], 32'd4);

    // JAL at PC 8 skips PC 12
    resetCore();
    dut.ROM_InstrMem0.rom[2] = encJ(21'd8, 5'd7);
    dut.ROM_InstrMem0.rom[3] = encI(12'd99, 5'd0, 3'd0, 5'd20);
    dut.ROM_InstrMem0.rom[4] = encI(12'd55, 5'd0, 3'd0, 5'd21);
    dut.RegFile0.regsfile_[7]  = 32'd0;
    dut.RegFile0.regsfile_[20] = 32'h0000_1234;
    dut.RegFile0.regsfile_[21] = 32'd0;
    pcSeq[0] = 32'd0; pcSeq[1] = 32'd4; pcSeq[2] = 32'd8; pcSeq[3] = 32'd0; pcSeq[4] = 32'd16;
    reset = 1'b0;
    for (int e = 0; e < 5; e++) begin
      applyStimulus(1);
      checkOutput($sformatf("jal_ifidPc%0d", e), ifidPc, pcSeq[e]);
      if (e == 3) begin
        checkOutput("jal_squashInstr", ifidInstr, 32'h0000_0013);
        checkOutput("jal_idexImm", idexImm, 32'd4);
        checkOutput("jal_idexData1", idexData1, 32'd8);
      end
    end
    checkOutput("jal_link", exmemWrtData, 32'd12);
    applyStimulus(6);
    checkOutput("jal_x7", dut.RegFile0.regsfile_[7], 32'd12);
    checkOutput("jal_x20_skipped", dut.RegFile0.regsfile_[20], 32'h0000_1234);
    checkOutput("jal_x21", dut.RegFile0.regsfile_[21], 32'd55);

    // Writes to x0 are discarded and never forwarded
    resetCore();
    dut.ROM_InstrMem0.rom[0] = encI(12'd5, 5'd0, 3'd0, 5'd0);
    dut.ROM_InstrMem0.rom[1] = encR(7'h00, 5'd0, 5'd0, 3'd0, 5'd8);
    dut.RegFile0.regsfile_[0] = 32'd0;
    dut.RegFile0.regsfile_[8] = 32'h0000_0055;
    reset = 1'b0;
    applyStimulus(4);
    checkOutput("x0_wbEn", 32'(wbWrtEn), 32'd1);
    checkOutput("x0_wbData", wbWrtData, 32'd5);
    applyStimulus(3);
    checkOutput("x0_stays0", dut.RegFile0.regsfile_[0], 32'd0);
    checkOutput("x0_x8", dut.RegFile0.regsfile_[8], 32'd0);

    // Reset mid-flight squashes addi x9 and restarts at PC 0
    resetCore();
    dut.ROM_InstrMem0.rom[0] = encI(12'd3, 5'd0, 3'd0, 5'd9);
    dut.RegFile0.regsfile_[9] = 32'h0000_0077;
    reset = 1'b0;
    applyStimulus(2);
    checkOutput("midrst_inflight", 32'(idexRegWrite), 32'd1);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("midrst_anyDebug", 32'(anyDebugSet), 32'd0);
    checkOutput("midrst_wbEn", 32'(wbWrtEn), 32'd0);
    applyStimulus(3);
    checkOutput("midrst_x9", dut.RegFile0.regsfile_[9], 32'h0000_0077);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("midrst_restartPc", ifidPc, 32'd0);
    checkOutput("midrst_restartInstr", ifidInstr, encI(12'd3, 5'd0, 3'd0, 5'd9));
    applyStimulus(4);
    checkOutput("midrst_x9_after", dut.RegFile0.regsfile_[9], 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end
endmodule
